// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Instruction-memory sequencer with two phases.
//            BOOT  - accepts 32-bit words from a program loader and writes each
//                    into the byte-addressed instruction memory as four
//                    little-endian byte writes (one byte per cycle).
//            RUN   - owns the PC and presents it as Inst_Address to the
//                    instruction memory, with stall (fetch_en=0) and branch
//                    redirect control from the pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_BYTES      instruction memory size in bytes (valid addr 0..MEM_BYTES-1)
//   RESET_PC       PC loaded on reset and on entry to RUN (word aligned)
// Ports
//   clk            clock, all state updates on the rising edge
//   reset_n        asynchronous active-low reset
//   load_valid     loader offers a word
//   load_ready     controller accepts the offered word this cycle
//   load_addr      byte address of the offered word (must be 4-aligned)
//   load_data      instruction word, byte 0 = load_data[7:0]
//   load_last      marks the final word of the program
//   fetch_en       1 = IF stage advances, 0 = stall (PC held)
//   branch_taken   redirect the PC this cycle
//   branch_target  redirect byte address (low two bits ignored)
//   Inst_Address   read address to the instruction memory (= PC)
//   mem_wr_en      byte write strobe to the instruction memory
//   mem_wr_addr    byte write address
//   mem_wr_byte    byte write data
//   fetch_valid    Inst_Address is an in-range fetch during RUN
//   boot_done      set once RUN is entered
//   load_err       sticky: a loader word was rejected
//   fetch_fault    sticky: the PC left the memory range during RUN
// ============================================================================
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        fetch_en,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_addr,
  output logic [7:0]  mem_wr_byte,
  output logic        fetch_valid,
  output logic        boot_done,
  output logic        load_err,
  output logic        fetch_fault
);

  // A full word at byte address a fits when a + 3 < MEM_BYTES. Comparing
  // a < MEM_BYTES - 3 instead avoids the carry out of a 64-bit a + 3, so an
  // address near 2^64 can never wrap into the valid range.
  localparam logic [63:0] C_WORD_LIMIT = 64'(MEM_BYTES) - 64'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_pc;
  logic [1:0]  r_byte_cnt;
  logic [63:0] r_addr;
  logic [31:0] r_data;
  logic        r_last_pend;
  logic        r_mem_wr_en;
  logic [63:0] r_mem_wr_addr;
  logic [7:0]  r_mem_wr_byte;
  logic        r_boot_done;
  logic        r_load_err;
  logic        r_fetch_fault;

  logic        w_word_ok;
  logic        w_pc_in_range;
  logic        w_enter_run;
  logic [1:0]  w_cnt_nxt;

  assign w_word_ok     = (load_addr[1:0] == 2'b00) && (load_addr < C_WORD_LIMIT);
  assign w_pc_in_range = (r_pc < C_WORD_LIMIT);
  assign w_cnt_nxt     = r_byte_cnt + 2'd1;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control outputs
  // In BOOT load_ready is 1, so load_valid alone means "word accepted".
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    w_enter_run = 1'b0;
    case (r_state)
      ST_BOOT: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (w_word_ok) begin
            w_state_nxt = ST_WRITE;
          end else if (load_last) begin
            // A rejected final word still ends the boot phase.
            w_state_nxt = ST_RUN;
            w_enter_run = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (r_byte_cnt == 2'd3) begin
          if (r_last_pend) begin
            w_state_nxt = ST_RUN;
            w_enter_run = 1'b1;
          end else begin
            w_state_nxt = ST_BOOT;
          end
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: byte-write sequencer, PC and sticky status flags.
  // The write port is registered so that byte k is on the bus exactly while
  // the FSM sits in WRITE with r_byte_cnt == k; the accept edge already
  // launches byte 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_byte_cnt    <= 2'd0;
      r_addr        <= 64'd0;
      r_data        <= 32'd0;
      r_last_pend   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= 64'd0;
      r_mem_wr_byte <= 8'd0;
      r_boot_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (load_valid) begin
            r_addr      <= load_addr;
            r_data      <= load_data;
            r_last_pend <= load_last;
            if (w_word_ok) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= load_addr;
              r_mem_wr_byte <= load_data[7:0];
              r_byte_cnt    <= 2'd0;
            end else begin
              r_load_err    <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (r_byte_cnt == 2'd3) begin
            r_mem_wr_en <= 1'b0;
            r_byte_cnt  <= 2'd0;
          end else begin
            r_byte_cnt    <= w_cnt_nxt;
            r_mem_wr_addr <= r_addr + {62'd0, w_cnt_nxt};
            r_mem_wr_byte <= r_data[{w_cnt_nxt, 3'b000} +: 8];
          end
        end
        ST_RUN: begin
          if (!w_pc_in_range) begin
            r_fetch_fault <= 1'b1;
          end
          // Branch beats stall; the PC keeps moving even when out of range
          // so a branch can bring fetches back into memory.
          if (branch_taken) begin
            r_pc <= branch_target & ~64'h3;
          end else if (fetch_en) begin
            r_pc <= r_pc + 64'd4;
          end
        end
        default: begin
        end
      endcase

      if (w_enter_run) begin
        r_pc        <= RESET_PC;
        r_boot_done <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Inst_Address = r_pc;
  assign fetch_valid  = (r_state == ST_RUN) && w_pc_in_range;
  assign mem_wr_en    = r_mem_wr_en;
  assign mem_wr_addr  = r_mem_wr_addr;
  assign mem_wr_byte  = r_mem_wr_byte;
  assign boot_done    = r_boot_done;
  assign load_err     = r_load_err;
  assign fetch_fault  = r_fetch_fault;

endmodule
`default_nettype wire
